// File: rtl/ifu_pkg.sv
// Shared instruction-fetch definitions: FSM state encoding, fault cause codes and the NOP
// instruction that the core also uses for reset and bubble slots.
package ifu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StOut,
    StDrain
  } ifu_state_e;

  typedef enum logic [1:0] {
    CauseNone       = 2'd0,
    CauseMisaligned = 2'd1,
    CauseBusErr     = 2'd2,
    CauseTimeout    = 2'd3
  } fault_cause_e;

  // addi x0, x0, 0
  localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_timer.sv
// Watchdog counter for the fetch unit's response wait.
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : zero the count (takes priority over en_i)
//   en_i       : count this cycle; saturates at all-ones, never wraps
//   expire_o   : count has reached TIMEOUT-1
module fetch_timer #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned Width = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [Width-1:0] Last = Width'(TIMEOUT - 1);
  localparam logic [Width-1:0] Max  = '1;

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != Max)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire_o = (count_q == Last);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one memory read per requested pc, one outstanding request at most,
// delivery to the core over a valid/ready handshake. Flush drops the in-flight or buffered
// entry; responses owed to dropped or timed-out requests are drained and discarded.
//   clk, rst                  : clock, synchronous active-high reset
//   pc_i, fetch_en_i          : core fetch request
//   flush_i                   : redirect, highest priority
//   inst_o, inst_pc_o         : delivered instruction and its address
//   inst_valid_o/inst_ready_i : delivery handshake
//   fault_o, fault_cause_o    : delivered entry is a fault (none/misaligned/bus error/timeout)
//   mem_req_*                 : read request channel (word-aligned address)
//   mem_rsp_*                 : read response channel (never back-pressured)
module inst_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     TIMEOUT  = 256,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(IFU_NOP_INST)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            fetch_en_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic            fault_o,
  output logic [1:0]      fault_cause_o,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rsp_data_i,
  input  logic            mem_rsp_err_i
);

  ifu_state_e      state_q, state_d;
  fault_cause_e    cause_q, cause_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] inst_q, inst_d;
  // A response is still owed by memory for a request whose result was dropped or timed out.
  logic            stale_q, stale_d;
  logic            timer_clear, timer_expire;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear),
    .en_i     (state_q == StWait),
    .expire_o (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cause_q <= CauseNone;
      addr_q  <= '0;
      inst_q  <= NOP_INST;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      stale_q <= stale_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    addr_d      = addr_q;
    inst_d      = inst_q;
    stale_d     = stale_q;
    timer_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fetch_en_i && !flush_i) begin
          addr_d = pc_i;
          if (pc_i[1:0] != 2'b00) begin
            state_d = StOut;
            inst_d  = NOP_INST;
            cause_d = CauseMisaligned;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (flush_i) begin
          // An accepted request still gets a response, which must be swallowed.
          if (mem_req_ready_i) begin
            state_d = StDrain;
            stale_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (mem_req_ready_i) begin
          state_d     = StWait;
          timer_clear = 1'b1;
        end
      end
      StWait: begin
        if (flush_i) begin
          if (mem_rsp_valid_i) begin
            state_d = StIdle;
          end else begin
            state_d = StDrain;
            stale_d = 1'b1;
          end
        end else if (mem_rsp_valid_i) begin
          state_d = StOut;
          inst_d  = mem_rsp_err_i ? NOP_INST : mem_rsp_data_i;
          cause_d = mem_rsp_err_i ? CauseBusErr : CauseNone;
        end else if (timer_expire) begin
          state_d = StOut;
          inst_d  = NOP_INST;
          cause_d = CauseTimeout;
          stale_d = 1'b1;
        end
      end
      StOut: begin
        // A late response landing while a timeout fault is presented settles the debt here.
        if (stale_q && mem_rsp_valid_i) begin
          stale_d = 1'b0;
        end
        if (flush_i || inst_ready_i) begin
          state_d = stale_d ? StDrain : StIdle;
        end
      end
      StDrain: begin
        if (mem_rsp_valid_i) begin
          state_d = StIdle;
          stale_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign inst_valid_o    = (state_q == StOut);
  assign inst_o          = inst_valid_o ? inst_q : NOP_INST;
  assign inst_pc_o       = addr_q;
  assign fault_o         = inst_valid_o && (cause_q != CauseNone);
  assign fault_cause_o   = inst_valid_o ? cause_q : CauseNone;
  assign mem_req_valid_o = (state_q == StReq);
  assign mem_req_addr_o  = {addr_q[XLEN-1:2], 2'b00};

  // A response is only legal while one is owed.
  assert property (@(posedge clk) disable iff (rst)
    mem_rsp_valid_i |-> ((state_q == StWait) || (state_q == StDrain) || stale_q));

endmodule
